// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for a 16x2 character-LCD write bus.
// Round-robin grant, latches the winner's RS/DATA and drives the full
// setup / EN pulse / hold / execution-wait cycle. Write-only: LCD_RW is 0.
// Optional power-up init sequence guarded by macro LCD_INIT_SEQ_EN.
module lcd_bus_arbiter #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 16,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2000,
    parameter int unsigned T_LONG  = 82000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [1:0] iREQ,
    input  logic       iRS0,
    input  logic [7:0] iDATA0,
    input  logic       iRS1,
    input  logic [7:0] iDATA1,
    output logic [1:0] oACK,
    output logic       oBUSY,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEnHi,
        StHold,
        StWait,
        StInit
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rr_last_q;

    logic             grant_vld;
    logic             grant_id;
    logic             is_long;

`ifdef LCD_INIT_SEQ_EN
    localparam int unsigned T_INIT = 750000;

    logic       init_active_q;
    logic [1:0] init_idx_q;

    // Power-up command list: function set, display on, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        unique case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction
`endif

    assign LCD_RW = 1'b0;

    // Round-robin pick: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        grant_vld = |iREQ;
        if (iREQ == 2'b11) begin
            grant_id = ~rr_last_q;
        end else begin
            grant_id = iREQ[1];
        end
    end

    // Clear and Home commands need the long execution wait.
    always_comb begin
        is_long = ~LCD_RS && ((LCD_DATA == 8'h01) || (LCD_DATA == 8'h02) ||
                              (LCD_DATA == 8'h03));
    end

    // Bus-cycle FSM with registered pin and handshake outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oACK      <= 2'b00;
            LCD_EN    <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DATA  <= 8'h00;
            rr_last_q <= 1'b1;
`ifdef LCD_INIT_SEQ_EN
            state_q       <= StInit;
            oBUSY         <= 1'b1;
            cnt_q         <= CNT_W'(T_INIT - 1);
            init_active_q <= 1'b1;
            init_idx_q    <= 2'd0;
`else
            state_q <= StIdle;
            oBUSY   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            oACK <= 2'b00;
            case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        LCD_RS    <= grant_id ? iRS1 : iRS0;
                        LCD_DATA  <= grant_id ? iDATA1 : iDATA0;
                        oACK      <= grant_id ? 2'b10 : 2'b01;
                        rr_last_q <= grant_id;
                        cnt_q     <= CNT_W'(T_SETUP - 1);
                        oBUSY     <= 1'b1;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        LCD_EN  <= 1'b1;
                        cnt_q   <= CNT_W'(T_EN - 1);
                        state_q <= StEnHi;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StEnHi: begin
                    if (cnt_q == '0) begin
                        LCD_EN  <= 1'b0;
                        cnt_q   <= CNT_W'(T_HOLD - 1);
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= is_long ? CNT_W'(T_LONG - 1) : CNT_W'(T_EXEC - 1);
                        state_q <= StWait;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
                        if (init_active_q && (init_idx_q != 2'd3)) begin
                            // Chain straight into the next init command.
                            init_idx_q <= init_idx_q + 2'd1;
                            LCD_DATA   <= init_cmd(init_idx_q + 2'd1);
                            cnt_q      <= CNT_W'(T_SETUP - 1);
                            state_q    <= StSetup;
                        end else begin
                            init_active_q <= 1'b0;
                            oBUSY         <= 1'b0;
                            state_q       <= StIdle;
                        end
`else
                        oBUSY   <= 1'b0;
                        state_q <= StIdle;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef LCD_INIT_SEQ_EN
                StInit: begin
                    if (cnt_q == '0) begin
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= init_cmd(2'd0);
                        cnt_q    <= CNT_W'(T_SETUP - 1);
                        state_q  <= StSetup;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                default: begin
                    LCD_EN  <= 1'b0;
                    oBUSY   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with shortened wait parameters.
module tb_lcd_bus_arbiter;

    localparam int unsigned TS = 2;
    localparam int unsigned TE = 16;
    localparam int unsigned TH = 2;
    localparam int unsigned TX = 40;
    localparam int unsigned TL = 150;
    localparam int unsigned SP = TS + TE + TH + TX + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic       rs0, rs1;
    logic [7:0] data0, data1;
    logic [1:0] ack;
    logic       busy;
    logic [7:0] lcd_data;
    logic       lcd_rw, lcd_en, lcd_rs;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt;

    lcd_bus_arbiter #(
        .T_SETUP (TS),
        .T_EN    (TE),
        .T_HOLD  (TH),
        .T_EXEC  (TX),
        .T_LONG  (TL),
        .CNT_W   (20)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iREQ     (req),
        .iRS0     (rs0),
        .iDATA0   (data0),
        .iRS1     (rs1),
        .iDATA1   (data1),
        .oACK     (ack),
        .oBUSY    (busy),
        .LCD_DATA (lcd_data),
        .LCD_RW   (lcd_rw),
        .LCD_EN   (lcd_en),
        .LCD_RS   (lcd_rs)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; req = 2'b00;
        rs0 = 1'b0; rs1 = 1'b0; data0 = 8'h00; data1 = 8'h00;

        // Reset values
        rst = 1'b1;
        step(2);
        check("rst_ack",  {30'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_en",   {31'd0, lcd_en}, 32'd0);
        check("rst_rs",   {31'd0, lcd_rs}, 32'd0);
        check("rst_data", {24'd0, lcd_data}, 32'h00);
        check("rst_rw",   {31'd0, lcd_rw}, 32'd0);
        rst = 1'b0;
        tick();

        // Single request from requester 0
        req = 2'b01; rs0 = 1'b1; data0 = 8'h41;
        tick();                                   // grant edge G
        check("s_ack",  {30'd0, ack}, 32'b01);
        check("s_rs",   {31'd0, lcd_rs}, 32'd1);
        check("s_data", {24'd0, lcd_data}, 32'h41);
        check("s_busy", {31'd0, busy}, 32'd1);
        req = 2'b00; data0 = 8'hFF; rs0 = 1'b0;  // post-ack changes must not leak
        tick();                                   // G+1
        check("s_ack_pulse", {30'd0, ack}, 32'd0);
        check("s_en_setup",  {31'd0, lcd_en}, 32'd0);
        cnt = 0;
        for (int i = 0; i < TE + 4; i++) begin
            tick();
            if (lcd_en) cnt++;
        end
        check("s_en_len", cnt, TE);
        step(TS + TE + TH + TX - 1 - (TE + 5));  // to G+TS+TE+TH+TX-1
        check("s_busy_end", {31'd0, busy}, 32'd1);
        tick();
        check("s_idle", {31'd0, busy}, 32'd0);
        check("s_latched", {24'd0, lcd_data}, 32'h41);
        check("s_latched_rs", {31'd0, lcd_rs}, 32'd1);

        // Simultaneous requests: alternate 0,1,0,1 with fixed spacing
        do_reset();
        req = 2'b11; rs0 = 1'b1; rs1 = 1'b1; data0 = 8'h41; data1 = 8'h42;
        for (int g = 0; g < 4; g++) begin
            tick();                               // grant edge
            check("rr_ack", {30'd0, ack}, (g % 2 == 0) ? 32'b01 : 32'b10);
            check("rr_data", {24'd0, lcd_data}, (g % 2 == 0) ? 32'h41 : 32'h42);
            tick();
            check("rr_en_lo", {31'd0, lcd_en}, 32'd0);
            tick();
            check("rr_en_rise", {31'd0, lcd_en}, 32'd1);
            step(SP - 3);                         // IDLE cycle before next grant
            check("rr_gap_ack", {30'd0, ack}, 32'd0);
            check("rr_gap_idle", {31'd0, busy}, 32'd0);
        end
        req = 2'b00;

        // Long command on requester 1: Clear
        do_reset();
        req = 2'b10; rs1 = 1'b0; data1 = 8'h01;
        tick();
        check("l_ack", {30'd0, ack}, 32'b10);
        req = 2'b00;
        step(TS + TE + TH + TL - 1);
        check("l_busy", {31'd0, busy}, 32'd1);
        tick();
        check("l_idle", {31'd0, busy}, 32'd0);

        // Same requester with 0x80: normal wait
        req = 2'b10; data1 = 8'h80;
        tick();
        check("n_ack", {30'd0, ack}, 32'b10);
        req = 2'b00;
        step(TS + TE + TH + TX - 1);
        check("n_busy", {31'd0, busy}, 32'd1);
        tick();
        check("n_idle", {31'd0, busy}, 32'd0);

        // Late request arrives mid EN_HI of a requester-1 write
        req = 2'b10; rs1 = 1'b1; data1 = 8'h55;
        tick();                                   // G
        check("late_ack1", {30'd0, ack}, 32'b10);
        req = 2'b00;
        step(10);                                 // G+10, inside EN_HI
        req = 2'b01; rs0 = 1'b0; data0 = 8'h66;
        cnt = 0;
        for (int i = 10; i < SP - 1; i++) begin
            tick();
            if (lcd_data !== 8'h55 || lcd_rs !== 1'b1 || ack !== 2'b00) cnt++;
        end
        check("late_no_glitch", cnt, 0);
        check("late_idle", {31'd0, busy}, 32'd0);
        tick();
        check("late_ack0", {30'd0, ack}, 32'b01);
        check("late_data", {24'd0, lcd_data}, 32'h66);
        check("late_rs", {31'd0, lcd_rs}, 32'd0);

        // Reset while EN is high aborts the write
        req = 2'b00;
        step(5);                                  // EN high
        check("ra_en_pre", {31'd0, lcd_en}, 32'd1);
        req = 2'b10; rst = 1'b1;
        tick();
        check("ra_en",   {31'd0, lcd_en}, 32'd0);
        check("ra_busy", {31'd0, busy}, 32'd0);
        check("ra_data", {24'd0, lcd_data}, 32'h00);
        check("ra_ack",  {30'd0, ack}, 32'd0);
        rst = 1'b0; req = 2'b00;
        tick();
        check("ra_ack2", {30'd0, ack}, 32'd0);
        check("ra_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single 16x2 character-LCD write bus between two requesters, e.g. a status/clock text generator and a menu/state display.
- Round-robin arbitration; the winner's byte is latched.
- Drives the full LCD write cycle: RS/data setup, EN pulse, hold, then a fixed execution wait.
- Sits between the display-content generators and the LCD_DATA/LCD_RW/LCD_EN/LCD_RS pins. Write-only; RW is tied to 0.

Parameters:
- T_SETUP, 2: cycles RS/DATA are stable before EN rises.
- T_EN, 16: cycles EN is held high.
- T_HOLD, 2: cycles RS/DATA are held after EN falls.
- T_EXEC, 2000: execution-wait cycles after a normal write (40 us at 50 MHz).
- T_LONG, 82000: execution-wait cycles after a Clear (0x01) or Home (0x02/0x03) command with RS=0.
- CNT_W, 20: timing counter width. Must hold max(T_LONG, 750000).

Ports:
- iCLK  in  1  system clock (CLOCK_50)
- iRST  in  1  synchronous, active-high reset
- iREQ  in  2  request per requester. Bit n is held high with data stable until oACK[n].
- iRS0  in  1  requester 0 register select (0=command, 1=data)
- iDATA0  in  8  requester 0 byte
- iRS1  in  1  requester 1 register select
- iDATA1  in  8  requester 1 byte
- oACK  out  2  one-cycle pulse: the request was latched
- oBUSY  out  1  high whenever not IDLE
- LCD_DATA  out  8  LCD data bus
- LCD_RW  out  1  constant 0
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select

Behaviour:
- One clock (iCLK). Reset is synchronous and active-high (iRST).
- Reset values: state=IDLE, oACK=0, oBUSY=0, LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, LCD_RW=0, rr_last=1 (requester 0 wins first tie).
- Reset mid-operation aborts on the next edge. EN drops immediately and no oACK is issued.
- States: IDLE -> SETUP -> EN_HI -> HOLD -> WAIT -> IDLE.
- IDLE, arbitration:
  - Only one request: that one wins.
  - Both requests: the requester not equal to rr_last wins.
  - On the winning edge: latch RS/DATA onto the LCD pins, pulse oACK[winner] for exactly one cycle, set rr_last=winner, load the counter, go to SETUP.
  - Arbitration uses iREQ as sampled in IDLE only. A request arriving during any other state waits; it is never dropped.
- SETUP: EN=0 for T_SETUP cycles.
- EN_HI: EN=1 for exactly T_EN cycles.
- HOLD: EN=0, RS/DATA unchanged, for T_HOLD cycles.
- WAIT: counts T_LONG if the latched RS=0 and DATA is in {0x01,0x02,0x03}; otherwise counts T_EXEC. RS/DATA keep their last value.
- Return to IDLE when the counter expires. A new grant can happen on the first IDLE cycle.
- Counter: loaded with (N-1) on state entry, decremented each cycle, transition when it equals 0. Every state therefore lasts exactly N cycles.
- Minimum spacing between EN rising edges: T_SETUP+T_EN+T_HOLD+T_EXEC+1 cycles (the +1 is the IDLE grant cycle).
- A requester that drops iREQ before oACK loses its request; no partial write occurs.
- Only the latched byte reaches the LCD. Changes on iDATAx after oACK have no effect.

Optional Feature:
- Macro: LCD_INIT_SEQ_EN.
- When defined:
  - After reset, the FSM enters INIT instead of IDLE. oBUSY=1 and iREQ is ignored.
  - Waits 750000 cycles (15 ms), then autonomously writes the commands 0x38, 0x0C, 0x01, 0x06 (RS=0) using the normal SETUP/EN_HI/HOLD/WAIT timing, including T_LONG after 0x01.
  - Then enters IDLE. No oACK pulses are produced during INIT.
- When undefined: reset goes straight to IDLE. Requesters are responsible for initialization.

Test Plan:
- Single request: iREQ=01, iRS0=1, iDATA0=0x41 after reset.
  - Expect oACK=01 for 1 cycle, LCD_RS=1, LCD_DATA=0x41.
  - Expect EN high for exactly 16 cycles, starting 2 cycles after the grant.
  - Expect oBUSY low again 2+16+2+2000 cycles after the grant.
- Simultaneous requests: iREQ=11 held, data 0x41/0x42, after reset.
  - Expect grants in the order 0,1,0,1.
  - Expect EN rising edges spaced exactly 2021 cycles apart.
- Long command: iRS1=0, iDATA1=0x01.
  - Expect WAIT lasting 82000 cycles.
  - Then repeat with 0x80 and expect a WAIT of 2000 cycles.
- Late request: iREQ0 asserted mid-EN_HI of a requester-1 write.
  - Expect no glitch on the LCD pins.
  - Expect oACK0 on the first IDLE cycle after WAIT.
- Reset mid-operation: assert iREQ, then iRST=1 for 1 cycle while EN=1.
  - Expect LCD_EN=0, oBUSY=0 and LCD_DATA=0x00 on the next edge.
  - Expect no oACK.
- With LCD_INIT_SEQ_EN defined: after reset, iREQ=11 is ignored.
  - Expect EN pulses carrying 0x38, 0x0C, 0x01, 0x06, the first starting 750000+2 cycles after reset.
  - Then requester 0 is granted first.
